// File: rtl/frame_buffer.sv
// Double-buffered frame store: writes fill the back bank, reads come from the front bank,
// and the banks exchange only on a frame boundary. A clear sweep can wipe the back bank.
module frame_buffer #(
  parameter int                DATA_W    = 12,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              swap_req,
  input  logic              frame_end,
  input  logic              clr_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              busy,
  output logic              front_sel
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // NOTE: the banks have no reset; clearing them is the sweep's job, and a reset
  // branch here would stop the tools from mapping them onto block RAM.
  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              r_front_sel;
  logic              r_swap_pending;
  logic              r_swap_done;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_busy;
  logic              w_clr_last;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_ext_wr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_swap;

  assign w_busy        = (r_state == S_CLEAR);
  assign w_clr_last    = (r_clr_addr == LAST_ADDR);
  assign w_wr_in_range = ({1'b0, w_addr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, r_addr} < DEPTH_L);

  // Clear FSM: one back-bank address per cycle while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clr_addr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_IDLE: begin
        w_clr_addr_nxt = '0;
        if (clr_req) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (w_clr_last) begin
          w_state_nxt    = S_IDLE;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Back-bank write port is shared by the sweep and external writes; the sweep owns it while busy.
  assign w_ext_wr  = w_en && !w_busy && w_wr_in_range;
  assign w_mem_we  = !rst && (w_busy || w_ext_wr);
  assign w_wr_addr = w_busy ? r_clr_addr : w_addr;
  assign w_wr_data = w_busy ? CLEAR_VAL : din;

  always_ff @(posedge clk) begin
    if (w_mem_we && r_front_sel) r_bank0[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && !r_front_sel) r_bank1[w_wr_addr] <= w_wr_data;
  end

  // Accesses in the swap cycle see the pre-toggle front_sel.
  assign w_rd_data = !w_rd_in_range ? '0 :
                     r_front_sel    ? r_bank1[r_addr] : r_bank0[r_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (r_en) begin
      r_dout       <= w_rd_data;
      r_dout_valid <= 1'b1;
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  // A same-cycle swap_req and frame_end swap directly without visiting pending.
  assign w_swap = (r_swap_pending || swap_req) && frame_end && !w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      if (w_swap) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign swap_pending = r_swap_pending;
  assign swap_done    = r_swap_done;
  assign busy         = w_busy;
  assign front_sel    = r_front_sel;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: a DEPTH=1024 instance for most steps and a
// DEPTH=1000 instance for out-of-range addressing; both see identical stimulus.
module tb_frame_buffer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] din;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              swap_req;
  logic              frame_end;
  logic              clr_req;

  logic [DATA_W-1:0] dout;
  logic              dout_valid, swap_pending, swap_done, busy, front_sel;
  logic [DATA_W-1:0] dout2;
  logic              dout_valid2, swap_pending2, swap_done2, busy2, front_sel2;

  int n_asserts = 0;
  int n_fail    = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  frame_buffer #(.DATA_W(DATA_W), .DEPTH(1024)) u_dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .din(din),
    .r_en(r_en), .r_addr(r_addr), .dout(dout), .dout_valid(dout_valid),
    .swap_req(swap_req), .frame_end(frame_end), .clr_req(clr_req),
    .swap_pending(swap_pending), .swap_done(swap_done), .busy(busy),
    .front_sel(front_sel)
  );

  frame_buffer #(.DATA_W(DATA_W), .DEPTH(1000)) u_dut2 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .din(din),
    .r_en(r_en), .r_addr(r_addr), .dout(dout2), .dout_valid(dout_valid2),
    .swap_req(swap_req), .frame_end(frame_end), .clr_req(clr_req),
    .swap_pending(swap_pending2), .swap_done(swap_done2), .busy(busy2),
    .front_sel(front_sel2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within 200 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; w_en = 1'b0; w_addr = '0; din = '0; r_en = 1'b0; r_addr = '0;
    swap_req = 1'b0; frame_end = 1'b0; clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_front_sel", front_sel, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);

    // Write 0xABC to back bank, swap with same-cycle request and frame_end
    w_en = 1'b1; w_addr = 10'h155; din = 12'hABC;
    tick();
    w_en = 1'b0;
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    check("imm_swap_front_sel", front_sel, 1);
    check("imm_swap_done", swap_done, 1);
    check("imm_swap_no_pending", swap_pending, 0);
    r_en = 1'b1; r_addr = 10'h155;
    tick();
    r_en = 1'b0;
    check("imm_read_dout", dout, 12'hABC);
    check("imm_read_valid", dout_valid, 1);
    check("imm_swap_done_cleared", swap_done, 0);
    tick();
    check("idle_read_valid_low", dout_valid, 0);
    check("idle_read_dout_held", dout, 12'hABC);

    // Deferred swap: request now, frame_end 15 cycles later, repeated requests collapse
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("defer_pending_set", swap_pending, 1);
    for (int i = 0; i < 6; i++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("defer_pending_hold", swap_pending, 1);
    check("defer_front_unchanged", front_sel, 1);
    check("defer_no_done", swap_done, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("defer_front_toggled", front_sel, 0);
    check("defer_pending_cleared", swap_pending, 0);
    check("defer_done_pulse", swap_done, 1);
    tick();
    check("defer_done_one_cycle", swap_done, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("collapse_no_second_swap", front_sel, 0);

    // Clear sweep of back bank (bank 1), swap request during the sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy_start", busy, 1);
    busy_cnt = 1;
    for (int i = 0; i < 2000 && busy === 1'b1; i++) begin
      if (busy_cnt == 10) begin
        swap_req = 1'b1; frame_end = 1'b1;
      end
      if (busy_cnt == 12) begin
        w_en = 1'b1; w_addr = 10'd5; din = 12'h777;
      end
      tick();
      if (busy_cnt == 10) begin
        swap_req = 1'b0; frame_end = 1'b0;
        check("clr_swap_deferred_pending", swap_pending, 1);
        check("clr_swap_deferred_front", front_sel, 0);
      end
      w_en = 1'b0;
      if (busy === 1'b1) busy_cnt++;
    end
    check("clr_busy_cycles", busy_cnt, 1024);
    check("clr_pending_after_sweep", swap_pending, 1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("clr_swap_after_sweep", front_sel, 1);
    check("clr_swap_done", swap_done, 1);
    r_en = 1'b1; r_addr = 10'h155;
    tick();
    check("clr_read_155", dout, 0);
    check("clr_read_155_valid", dout_valid, 1);
    r_addr = 10'd5;
    tick();
    check("clr_busy_write_dropped", dout, 0);
    r_addr = 10'd1023;
    tick();
    r_en = 1'b0;
    check("clr_read_1023", dout, 0);

    // Swap-cycle access: read sees old front, write lands in old back (new front)
    w_en = 1'b1; w_addr = 10'd1023; din = 12'h123;
    r_en = 1'b1; r_addr = 10'd1023;
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    w_en = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
    check("swapcyc_read_old_front", dout, 0);
    check("swapcyc_read_valid", dout_valid, 1);
    check("swapcyc_front_sel", front_sel, 0);
    tick();
    check("swapcyc_write_in_new_front", dout, 12'h123);
    r_en = 1'b0;
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    r_en = 1'b1;
    tick();
    check("swap2_read_cleared_bank", dout, 0);
    r_en = 1'b0;
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("swap3_read_1023", dout, 12'h123);
    check("swap3_front_sel", front_sel, 0);

    // Out-of-range addressing on the DEPTH=1000 instance
    w_en = 1'b1; w_addr = 10'd1010; din = 12'h5A5;
    tick();
    w_addr = 10'd999; din = 12'h3E7;
    tick();
    w_en = 1'b0;
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    check("d1000_front_sel", front_sel2, 1);
    r_en = 1'b1; r_addr = 10'd1010;
    tick();
    check("d1000_oor_read_dout", dout2, 0);
    check("d1000_oor_read_valid", dout_valid2, 1);
    check("d1024_read_1010", dout, 12'h5A5);
    r_addr = 10'd999;
    tick();
    r_en = 1'b0;
    check("d1000_read_999", dout2, 12'h3E7);

    // Reset in the middle of a clear sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 299; i++) tick();
    check("midclr_busy", busy, 1);
    check("midclr_pending", swap_pending, 1);
    check("midclr_front_sel", front_sel, 1);
    rst = 1'b1; r_en = 1'b1; r_addr = 10'd7;
    tick();
    rst = 1'b0; r_en = 1'b0;
    check("midclr_rst_busy", busy, 0);
    check("midclr_rst_front_sel", front_sel, 0);
    check("midclr_rst_pending", swap_pending, 0);
    check("midclr_rst_dout_valid", dout_valid, 0);
    check("midclr_rst_dout", dout, 0);
    tick();
    check("midclr_stays_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
